// File: rtl/tenkey_debounce_if.sv
// Key-pad conditioner bundle: raw switch lines in, one-hot key pulses and status out.
// No latency of its own; pure wiring between conditioner and consumer.
// No backpressure: pulses are fire-and-forget, the consumer must sample every cycle.
interface tenkey_debounce_if;
  logic [9:0] sw_raw;
  logic [9:0] tenkey;
  logic       key_valid;
  logic       multi_err;
  logic       busy;

  // Conditioner side
  modport master (
    input  sw_raw,
    output tenkey,
    output key_valid,
    output multi_err,
    output busy
  );

  // Key pad / lock side
  modport slave (
    output sw_raw,
    input  tenkey,
    input  key_valid,
    input  multi_err,
    input  busy
  );
endinterface

// File: rtl/tenkey_debounce.sv
// 10-key synchroniser/debouncer: one single-cycle one-hot pulse per accepted press, multi-key flagged.
// Latency: raw change to output pulse is DEBOUNCE_CYCLES+4 clocks; release-to-idle likewise.
// No backpressure: outputs are pulses; optional auto-repeat enabled by macro TENKEY_REPEAT_EN.
module tenkey_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_PERIOD   = 250
) (
  input logic              clk,
  input logic              reset,
  tenkey_debounce_if.master kp
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HELD = 1'b1;

  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [9:0]       s1_q, s1_d;
  logic [9:0]       s2_q, s2_d;
  logic [9:0]       prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:0]       state_q, state_d;
  logic [9:0]       tenkey_q, tenkey_d;
  logic             key_valid_q, key_valid_d;
  logic             multi_err_q, multi_err_d;

  logic stable;
  logic prev_zero;
  logic prev_onehot;

  assign stable      = (cnt_q == DB_MAX);
  assign prev_zero   = (prev_q == 10'd0);
  assign prev_onehot = !prev_zero && ((prev_q & (prev_q - 10'd1)) == 10'd0);

`ifdef TENKEY_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_DLY = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RPT_PER = CNT_W'(REPEAT_PERIOD);

  // rep_q marks that the first (long) repeat delay has already elapsed
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic             rep_q, rep_d;
  logic [CNT_W-1:0] rcnt_inc;

  assign rcnt_inc = rcnt_q + 1'b1;
`endif

  // Two-flop synchroniser, one-cycle history and saturating stability counter
  always_comb begin
    s1_d   = kp.sw_raw;
    s2_d   = s1_q;
    prev_d = s2_q;
    if (s2_q != prev_q) begin
      cnt_d = '0;
    end else if (!stable) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Press/release FSM; a new pulse only ever comes out of IDLE (or the repeat timer)
  always_comb begin
    state_d     = state_q;
    tenkey_d    = '0;
    key_valid_d = 1'b0;
    multi_err_d = 1'b0;
`ifdef TENKEY_REPEAT_EN
    rcnt_d      = '0;
    rep_d       = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (stable && prev_onehot) begin
          tenkey_d    = prev_q;
          key_valid_d = 1'b1;
          state_d     = S_HELD;
        end else if (stable && !prev_zero) begin
          multi_err_d = 1'b1;
          state_d     = S_HELD;
        end
      end
      default: begin
        if (stable && prev_zero) begin
          state_d = S_IDLE;
        end
`ifdef TENKEY_REPEAT_EN
        // Only a single, still-stable key keeps the repeat timer running
        if (stable && prev_onehot && (s2_q == prev_q)) begin
          rep_d = rep_q;
          if (!rep_q && (rcnt_inc == RPT_DLY)) begin
            tenkey_d    = prev_q;
            key_valid_d = 1'b1;
            rep_d       = 1'b1;
          end else if (rep_q && (rcnt_inc == RPT_PER)) begin
            tenkey_d    = prev_q;
            key_valid_d = 1'b1;
          end else begin
            rcnt_d = rcnt_inc;
          end
        end
`endif
      end
    endcase
  end

  // State registers; reset parks the FSM in HELD so a key held through reset is ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q        <= '0;
      s2_q        <= '0;
      prev_q      <= '0;
      cnt_q       <= '0;
      state_q     <= S_HELD;
      tenkey_q    <= '0;
      key_valid_q <= 1'b0;
      multi_err_q <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      tenkey_q    <= tenkey_d;
      key_valid_q <= key_valid_d;
      multi_err_q <= multi_err_d;
    end
  end

`ifdef TENKEY_REPEAT_EN
  // Auto-repeat timer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      rcnt_q <= rcnt_d;
      rep_q  <= rep_d;
    end
  end
`endif

  assign kp.tenkey    = tenkey_q;
  assign kp.key_valid = key_valid_q;
  assign kp.multi_err = multi_err_q;
  assign kp.busy      = (state_q == S_HELD);

endmodule
